id_stage: RTL and testbench

Instruction-decode stage of the five-stage LoongArch32 pipeline. Sits directly downstream of the fetch stage and upstream of the execute stage. Latches one fetched instruction and its PC, decodes a fixed integer subset, and reads operands from an internal register file with EX/MEM/WB forwarding. It resolves branches (returning `br_zip` to fetch), stalls on load-use hazards, and drops its contents on exception or ERTN flush.

---
 rtl/cpu_defs.sv | 101 ++++++++++
 rtl/id_stage_if.sv | 23 ++
 rtl/regfile.sv | 27 ++
 rtl/id_stage.sv | 190 +++++++++++++++++++
 tb/tb_id_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the decode stage: opcode match constants, ALU
// one-hot indices, zip/bus widths, the ds2es_bus layout, and helpers for
// forwarding-path matching.
package cpu_defs;

    // Widths of the inter-stage bundles
    localparam int unsigned BR_ZIP_W    = 33;
    localparam int unsigned FWD_ZIP_W   = 40;
    localparam int unsigned WS_ZIP_W    = 38;
    localparam int unsigned DS2ES_BUS_W = 151;

    // ALU operation one-hot bit positions
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    // inst[31:15] matches
    localparam logic [16:0] OP17_ADD_W   = 17'h00020;
    localparam logic [16:0] OP17_SUB_W   = 17'h00022;
    localparam logic [16:0] OP17_SLT     = 17'h00024;
    localparam logic [16:0] OP17_SLTU    = 17'h00025;
    localparam logic [16:0] OP17_NOR     = 17'h00028;
    localparam logic [16:0] OP17_AND     = 17'h00029;
    localparam logic [16:0] OP17_OR      = 17'h0002a;
    localparam logic [16:0] OP17_XOR     = 17'h0002b;
    localparam logic [16:0] OP17_SYSCALL = 17'h00056;
    localparam logic [16:0] OP17_SLLI_W  = 17'h00081;
    localparam logic [16:0] OP17_SRLI_W  = 17'h00089;
    localparam logic [16:0] OP17_SRAI_W  = 17'h00091;
    // inst[31:22] matches
    localparam logic [9:0]  OP10_ADDI_W  = 10'h00a;
    localparam logic [9:0]  OP10_LD_W    = 10'h0a2;
    localparam logic [9:0]  OP10_ST_W    = 10'h0a6;
    // inst[31:25] match
    localparam logic [6:0]  OP7_LU12I_W  = 7'h0a;
    // inst[31:26] matches
    localparam logic [5:0]  OP6_JIRL     = 6'h13;
    localparam logic [5:0]  OP6_B        = 6'h14;
    localparam logic [5:0]  OP6_BL       = 6'h15;
    localparam logic [5:0]  OP6_BEQ      = 6'h16;
    localparam logic [5:0]  OP6_BNE      = 6'h17;
    // full-word match
    localparam logic [31:0] INST_ERTN    = 32'h06483800;

    typedef struct packed {
        logic        valid;
        logic        rf_we;
        logic        is_load;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } fwd_zip_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ws_zip_t;

    typedef struct packed {
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic        rf_we;
        logic [4:0]  dest;
        logic        mem_we;
        logic        res_from_mem;
        logic [31:0] pc;
        logic        sys;
        logic        ertn;
        logic        ine;
    } ds2es_bus_t;

    // A later stage supplies src when it will write that register; r0 never matches.
    function automatic logic fwd_hit(input fwd_zip_t zip, input logic [4:0] src);
        return zip.valid && zip.rf_we && (zip.waddr == src) && (src != 5'd0);
    endfunction

    // Operand value with EX > MEM > WB > register-file priority.
    function automatic logic [31:0] fwd_value(input logic [4:0]  src,
                                              input fwd_zip_t    es,
                                              input fwd_zip_t    ms,
                                              input ws_zip_t     ws,
                                              input logic [31:0] rf);
        if (src == 5'd0)                             return '0;
        if (fwd_hit(es, src))                        return es.wdata;
        if (fwd_hit(ms, src))                        return ms.wdata;
        if (ws.rf_we && (ws.waddr == src))           return ws.wdata;
        return rf;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch->decode->execute handshake bundle.
//   master: upstream/downstream pipeline side (drives instruction, es_allowin)
//   slave : decode stage (drives allowin, branch zip, decoded payload)
interface id_stage_if;
    logic                               fs2ds_valid;
    logic [31:0]                        fs_inst;
    logic [31:0]                        fs_pc;
    logic                               ds_allowin;
    logic [cpu_defs::BR_ZIP_W-1:0]      br_zip;
    logic                               es_allowin;
    logic                               ds2es_valid;
    logic [cpu_defs::DS2ES_BUS_W-1:0]   ds2es_bus;

    modport master (
        output fs2ds_valid, fs_inst, fs_pc, es_allowin,
        input  ds_allowin, br_zip, ds2es_valid, ds2es_bus
    );

    modport slave (
        input  fs2ds_valid, fs_inst, fs_pc, es_allowin,
        output ds_allowin, br_zip, ds2es_valid, ds2es_bus
    );
endinterface

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one write port.
//   clk            : write clock
//   raddr1/rdata1  : read port 1
//   raddr2/rdata2  : read port 2
//   we/waddr/wdata : write port; writes to r0 are dropped
// Contents are not reset.
module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] rf_q [32];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            rf_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : rf_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : rf_q[raddr2];
endmodule

// File: rtl/id_stage.sv
// LoongArch32 instruction-decode stage.
//   clk, reset     : clock, synchronous active-high reset
//   pipe (slave)   : fetch input, allowin, br_zip, execute handshake/payload
//   es/ms_fwd_zip  : {valid, rf_we, is_load, waddr, wdata} from EX / MEM
//   ws_rf_zip      : {rf_we, waddr, wdata} register-file write and WB forward
//   wb_ex, ertn_flush : pipeline flush
module id_stage
    import cpu_defs::*;
(
    input  logic                 clk,
    input  logic                 reset,
    id_stage_if.slave            pipe,
    input  logic [FWD_ZIP_W-1:0] es_fwd_zip,
    input  logic [FWD_ZIP_W-1:0] ms_fwd_zip,
    input  logic [WS_ZIP_W-1:0]  ws_rf_zip,
    input  logic                 wb_ex,
    input  logic                 ertn_flush
);
    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_inst_q,  ds_inst_d;
    logic [31:0] ds_pc_q,    ds_pc_d;

    fwd_zip_t es_zip, ms_zip;
    ws_zip_t  ws_zip;
    assign es_zip = es_fwd_zip;
    assign ms_zip = ms_fwd_zip;
    assign ws_zip = ws_rf_zip;

    logic flush, load_use, ds_ready_go, ds_allowin, br_taken;
    logic [31:0] br_target;

    logic [4:0]  rd, rj, rk, rs1, rs2;
    logic inst_add, inst_sub, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
    logic inst_slli, inst_srli, inst_srai, inst_addi, inst_lu12i, inst_ld, inst_st;
    logic inst_beq, inst_bne, inst_jirl, inst_b, inst_bl, inst_syscall, inst_ertn;
    logic is_3r, is_shift, use_rj, use_rs2, use_imm, ine, eq;
    logic [31:0] imm, offs16, offs26;
    logic [31:0] rf_rdata1, rf_rdata2, rj_value, rkd_value;
    ds2es_bus_t  bus;

    // ---------------- decode ----------------
    always_comb begin
        rd = ds_inst_q[4:0];
        rj = ds_inst_q[9:5];
        rk = ds_inst_q[14:10];

        inst_add     = ds_inst_q[31:15] == OP17_ADD_W;
        inst_sub     = ds_inst_q[31:15] == OP17_SUB_W;
        inst_slt     = ds_inst_q[31:15] == OP17_SLT;
        inst_sltu    = ds_inst_q[31:15] == OP17_SLTU;
        inst_and     = ds_inst_q[31:15] == OP17_AND;
        inst_or      = ds_inst_q[31:15] == OP17_OR;
        inst_nor     = ds_inst_q[31:15] == OP17_NOR;
        inst_xor     = ds_inst_q[31:15] == OP17_XOR;
        inst_syscall = ds_inst_q[31:15] == OP17_SYSCALL;
        inst_slli    = ds_inst_q[31:15] == OP17_SLLI_W;
        inst_srli    = ds_inst_q[31:15] == OP17_SRLI_W;
        inst_srai    = ds_inst_q[31:15] == OP17_SRAI_W;
        inst_addi    = ds_inst_q[31:22] == OP10_ADDI_W;
        inst_ld      = ds_inst_q[31:22] == OP10_LD_W;
        inst_st      = ds_inst_q[31:22] == OP10_ST_W;
        inst_lu12i   = ds_inst_q[31:25] == OP7_LU12I_W;
        inst_jirl    = ds_inst_q[31:26] == OP6_JIRL;
        inst_b       = ds_inst_q[31:26] == OP6_B;
        inst_bl      = ds_inst_q[31:26] == OP6_BL;
        inst_beq     = ds_inst_q[31:26] == OP6_BEQ;
        inst_bne     = ds_inst_q[31:26] == OP6_BNE;
        inst_ertn    = ds_inst_q == INST_ERTN;

        is_3r    = inst_add | inst_sub | inst_slt | inst_sltu |
                   inst_and | inst_or  | inst_nor | inst_xor;
        is_shift = inst_slli | inst_srli | inst_srai;
        ine      = ~(is_3r | is_shift | inst_addi | inst_lu12i | inst_ld | inst_st |
                     inst_beq | inst_bne | inst_jirl | inst_b | inst_bl |
                     inst_syscall | inst_ertn);

        use_rj  = is_3r | is_shift | inst_addi | inst_ld | inst_st |
                  inst_beq | inst_bne | inst_jirl;
        use_rs2 = is_3r | inst_st | inst_beq | inst_bne;
        use_imm = is_shift | inst_addi | inst_ld | inst_st | inst_lu12i;

        // Unused source fields are steered to r0 so they can neither
        // forward garbage nor raise a false load-use stall.
        rs1 = use_rj  ? rj : 5'd0;
        rs2 = use_rs2 ? ((inst_st | inst_beq | inst_bne) ? rd : rk) : 5'd0;

        imm = '0;
        if (is_shift)
            imm = {27'd0, rk};
        else if (inst_addi | inst_ld | inst_st)
            imm = {{20{ds_inst_q[21]}}, ds_inst_q[21:10]};
        else if (inst_lu12i)
            imm = {ds_inst_q[24:5], 12'd0};

        offs16 = {{14{ds_inst_q[25]}}, ds_inst_q[25:10], 2'b00};
        offs26 = {{4{ds_inst_q[9]}}, ds_inst_q[9:0], ds_inst_q[25:10], 2'b00};
    end

    regfile u_regfile (
        .clk    (clk),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2),
        .rdata2 (rf_rdata2),
        .we     (ws_zip.rf_we),
        .waddr  (ws_zip.waddr),
        .wdata  (ws_zip.wdata)
    );

    assign rj_value  = fwd_value(rs1, es_zip, ms_zip, ws_zip, rf_rdata1);
    assign rkd_value = fwd_value(rs2, es_zip, ms_zip, ws_zip, rf_rdata2);
    assign eq        = rj_value == rkd_value;

    // ---------------- hazards and handshake ----------------
    assign flush    = wb_ex | ertn_flush;
    assign load_use = ds_valid_q && es_zip.is_load &&
                      ((use_rj  && fwd_hit(es_zip, rs1)) ||
                       (use_rs2 && fwd_hit(es_zip, rs2)));
    assign ds_ready_go = ~load_use;
    assign ds_allowin  = ~ds_valid_q | (ds_ready_go & pipe.es_allowin);

    assign br_taken = ds_valid_q & ds_ready_go & ~flush &
                      (inst_b | inst_bl | inst_jirl | (inst_beq & eq) | (inst_bne & ~eq));
    assign br_target = inst_jirl          ? rj_value + offs16 :
                       (inst_b | inst_bl) ? ds_pc_q  + offs26 :
                                            ds_pc_q  + offs16;

    assign pipe.ds_allowin  = ds_allowin;
    assign pipe.br_zip      = br_taken ? {1'b1, br_target} : '0;
    assign pipe.ds2es_valid = ds_valid_q & ds_ready_go & ~flush;

    // ---------------- payload ----------------
    always_comb begin
        bus = '0;
        bus.alu_op[ALU_ADD]  = inst_add | inst_addi | inst_ld | inst_st | inst_jirl | inst_bl;
        bus.alu_op[ALU_SUB]  = inst_sub;
        bus.alu_op[ALU_SLT]  = inst_slt;
        bus.alu_op[ALU_SLTU] = inst_sltu;
        bus.alu_op[ALU_AND]  = inst_and;
        bus.alu_op[ALU_NOR]  = inst_nor;
        bus.alu_op[ALU_OR]   = inst_or;
        bus.alu_op[ALU_XOR]  = inst_xor;
        bus.alu_op[ALU_SLL]  = inst_slli;
        bus.alu_op[ALU_SRL]  = inst_srli;
        bus.alu_op[ALU_SRA]  = inst_srai;
        bus.alu_op[ALU_LUI]  = inst_lu12i;
        bus.src1         = (inst_bl | inst_jirl) ? ds_pc_q : rj_value;
        bus.src2         = (inst_bl | inst_jirl) ? 32'd4 : (use_imm ? imm : rkd_value);
        bus.rkd_value    = rkd_value;
        bus.rf_we        = ~ine & ~(inst_st | inst_beq | inst_bne | inst_b |
                                    inst_syscall | inst_ertn);
        bus.dest         = inst_bl ? 5'd1 : rd;
        bus.mem_we       = inst_st;
        bus.res_from_mem = inst_ld;
        bus.pc           = ds_pc_q;
        bus.sys          = inst_syscall;
        bus.ertn         = inst_ertn;
        bus.ine          = ine;
    end

    assign pipe.ds2es_bus = bus;

    // ---------------- state ----------------
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_inst_d  = ds_inst_q;
        ds_pc_d    = ds_pc_q;
        if (flush)
            ds_valid_d = 1'b0;
        else if (ds_allowin)
            // a taken branch squashes the wrong-path instruction offered now
            ds_valid_d = pipe.fs2ds_valid & ~br_taken;
        if (ds_allowin && pipe.fs2ds_valid) begin
            ds_inst_d = pipe.fs_inst;
            ds_pc_d   = pipe.fs_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_inst_q  <= '0;
            ds_pc_q    <= 32'h1BFF_FFFC;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_inst_q  <= ds_inst_d;
            ds_pc_q    <= ds_pc_d;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
    logic clk = 1'b0;
    logic reset;
    logic [39:0] es_fwd_zip, ms_fwd_zip;
    logic [37:0] ws_rf_zip;
    logic wb_ex, ertn_flush;

    id_stage_if bus_if ();

    id_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pipe       (bus_if.slave),
        .es_fwd_zip (es_fwd_zip),
        .ms_fwd_zip (ms_fwd_zip),
        .ws_rf_zip  (ws_rf_zip),
        .wb_ex      (wb_ex),
        .ertn_flush (ertn_flush)
    );

    always #5 clk = ~clk;

    // Independent view of the payload layout, MSB first.
    typedef struct packed {
        logic [11:0] alu_op;
        logic [31:0] src1, src2, rkd;
        logic        rf_we;
        logic [4:0]  dest;
        logic        mem_we, res_mem;
        logic [31:0] pc;
        logic [2:0]  flags;   // {sys, ertn, ine}
    } tb_bus_t;

    typedef struct {
        logic [31:0] inst;
        tb_bus_t     exp;
        logic [32:0] br;
    } vec_t;

    localparam logic [11:0] A_ADD = 12'h001, A_SUB = 12'h002, A_SLT = 12'h004, A_SLTU = 12'h008,
                            A_AND = 12'h010, A_NOR = 12'h020, A_OR  = 12'h040, A_XOR  = 12'h080,
                            A_SLL = 12'h100, A_SRL = 12'h200, A_SRA = 12'h400, A_LUI  = 12'h800;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    tb_bus_t b, b_hold;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [11:0] alu, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] rkd, input logic we, input logic [4:0] dest,
                                input logic mw, input logic rm, input logic [2:0] fl,
                                input logic [32:0] br);
        vec_t v;
        v.inst = inst;
        v.exp  = '{alu_op: alu, src1: s1, src2: s2, rkd: rkd, rf_we: we, dest: dest,
                   mem_we: mw, res_mem: rm, pc: pc, flags: fl};
        v.br   = br;
        vecs.push_back(v);
    endfunction

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        ws_rf_zip = {1'b1, a, d};
        @(posedge clk); #1;
        ws_rf_zip = '0;
    endtask

    // Offer one instruction; returns #1 after the edge that latched it.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        bus_if.fs2ds_valid = 1'b1;
        bus_if.fs_inst     = inst;
        bus_if.fs_pc       = pc;
        @(posedge clk); #1;
        bus_if.fs2ds_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus_if.fs2ds_valid = 1'b0;
        bus_if.fs_inst = '0;
        bus_if.fs_pc = '0;
        bus_if.es_allowin = 1'b1;
        es_fwd_zip = '0; ms_fwd_zip = '0; ws_rf_zip = '0;
        wb_ex = 1'b0; ertn_flush = 1'b0;

        // inst, pc, alu, src1, src2, rkd, we, dest, mem_we, res_mem, flags, br_zip
        add({10'h00a, 12'h7ff, 5'd0, 5'd4},  32'h1C000000, A_ADD, 32'h0, 32'h7FF, 32'h0, 1, 4, 0, 0, 3'b000, 33'h0);
        add({17'h20, 5'd3, 5'd1, 5'd6},      32'h1C000004, A_ADD, 32'h3, 32'h80000000, 32'h80000000, 1, 6, 0, 0, 3'b000, 33'h0);
        add({17'h22, 5'd1, 5'd3, 5'd9},      32'h1C000008, A_SUB, 32'h80000000, 32'h3, 32'h3, 1, 9, 0, 0, 3'b000, 33'h0);
        add({17'h24, 5'd7, 5'd1, 5'd10},     32'h1C00000C, A_SLT, 32'h3, 32'h5, 32'h5, 1, 10, 0, 0, 3'b000, 33'h0);
        add({17'h25, 5'd3, 5'd7, 5'd11},     32'h1C000010, A_SLTU, 32'h5, 32'h80000000, 32'h80000000, 1, 11, 0, 0, 3'b000, 33'h0);
        add({17'h29, 5'd2, 5'd1, 5'd12},     32'h1C000014, A_AND, 32'h3, 32'h3, 32'h3, 1, 12, 0, 0, 3'b000, 33'h0);
        add({17'h28, 5'd7, 5'd0, 5'd13},     32'h1C000018, A_NOR, 32'h0, 32'h5, 32'h5, 1, 13, 0, 0, 3'b000, 33'h0);
        add({17'h2a, 5'd1, 5'd7, 5'd14},     32'h1C00001C, A_OR, 32'h5, 32'h3, 32'h3, 1, 14, 0, 0, 3'b000, 33'h0);
        add({17'h2b, 5'd7, 5'd3, 5'd15},     32'h1C000020, A_XOR, 32'h80000000, 32'h5, 32'h5, 1, 15, 0, 0, 3'b000, 33'h0);
        add({17'h81, 5'd31, 5'd7, 5'd16},    32'h1C000024, A_SLL, 32'h5, 32'd31, 32'h0, 1, 16, 0, 0, 3'b000, 33'h0);
        add({17'h89, 5'd4, 5'd3, 5'd17},     32'h1C000028, A_SRL, 32'h80000000, 32'd4, 32'h0, 1, 17, 0, 0, 3'b000, 33'h0);
        add({17'h91, 5'd1, 5'd3, 5'd18},     32'h1C00002C, A_SRA, 32'h80000000, 32'd1, 32'h0, 1, 18, 0, 0, 3'b000, 33'h0);
        add({7'h0a, 20'h80001, 5'd19},       32'h1C000030, A_LUI, 32'h0, 32'h80001000, 32'h0, 1, 19, 0, 0, 3'b000, 33'h0);
        add({10'h0a2, 12'hffc, 5'd7, 5'd20}, 32'h1C000034, A_ADD, 32'h5, 32'hFFFFFFFC, 32'h0, 1, 20, 0, 1, 3'b000, 33'h0);
        add({10'h0a6, 12'h008, 5'd1, 5'd7},  32'h1C000038, A_ADD, 32'h3, 32'h8, 32'h5, 0, 7, 1, 0, 3'b000, 33'h0);
        add({6'h16, 16'h0010, 5'd1, 5'd2},   32'h1C000100, 12'h0, 32'h3, 32'h3, 32'h3, 0, 2, 0, 0, 3'b000, {1'b1, 32'h1C000140});
        add({6'h17, 16'hfffe, 5'd1, 5'd2},   32'h1C000200, 12'h0, 32'h3, 32'h3, 32'h3, 0, 2, 0, 0, 3'b000, 33'h0);
        add({6'h17, 16'hfffe, 5'd1, 5'd3},   32'h1C000200, 12'h0, 32'h3, 32'h80000000, 32'h80000000, 0, 3, 0, 0, 3'b000, {1'b1, 32'h1C0001F8});
        add({6'h14, 16'h0400, 10'h000},      32'h1C000300, 12'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 3'b000, {1'b1, 32'h1C001300});
        add({6'h15, 16'hffff, 10'h3ff},      32'h1C000400, A_ADD, 32'h1C000400, 32'h4, 32'h0, 1, 1, 0, 0, 3'b000, {1'b1, 32'h1C0003FC});
        add({6'h13, 16'h0004, 5'd7, 5'd1},   32'h1C000500, A_ADD, 32'h1C000500, 32'h4, 32'h0, 1, 1, 0, 0, 3'b000, {1'b1, 32'h00000015});
        add({17'h56, 15'h0000},              32'h1C000600, 12'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 3'b100, 33'h0);
        add(32'h06483800,                    32'h1C000604, 12'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 3'b010, 33'h0);
        add(32'h00000000,                    32'h1C000608, 12'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 3'b001, 33'h0);
        add({17'h20, 5'd0, 5'd0, 5'd8},      32'h1C00060C, A_ADD, 32'h0, 32'h0, 32'h0, 1, 8, 0, 0, 3'b000, 33'h0);

        // ---- reset ----
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_valid",   bus_if.ds2es_valid, 1'b0);
        chk("reset_br_zip",  bus_if.br_zip, 33'h0);
        chk("reset_allowin", bus_if.ds_allowin, 1'b1);

        // ---- register file setup (r0 write must be ignored) ----
        rf_write(5'd1, 32'h3);
        rf_write(5'd2, 32'h3);
        rf_write(5'd3, 32'h80000000);
        rf_write(5'd7, 32'h5);
        rf_write(5'd0, 32'hFFFFFFFF);

        // ---- table of single instructions ----
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].inst, vecs[i].exp.pc);
            b = bus_if.ds2es_bus;
            chk($sformatf("vec%0d_valid", i), bus_if.ds2es_valid, 1'b1);
            chk($sformatf("vec%0d_bus", i),   b, vecs[i].exp);
            chk($sformatf("vec%0d_br", i),    bus_if.br_zip, vecs[i].br);
            idle();
        end

        // ---- load-use stall, MEM forwarding, back-pressure ----
        issue({17'h20, 5'd5, 5'd5, 5'd6}, 32'h1C000700);
        es_fwd_zip = {1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        bus_if.fs2ds_valid = 1'b1;
        bus_if.fs_inst = {17'h28, 5'd7, 5'd0, 5'd13};
        bus_if.fs_pc = 32'h1C000704;
        #1;
        chk("lu_allowin", bus_if.ds_allowin, 1'b0);
        chk("lu_valid",   bus_if.ds2es_valid, 1'b0);
        @(posedge clk); #1;
        es_fwd_zip = '0;
        ms_fwd_zip = {1'b1, 1'b1, 1'b1, 5'd5, 32'h12345678};
        #1;
        b = bus_if.ds2es_bus;
        chk("lu_release_valid", bus_if.ds2es_valid, 1'b1);
        chk("lu_src1",          b.src1, 32'h12345678);
        chk("lu_src2",          b.src2, 32'h12345678);
        chk("lu_pc_held",       b.pc, 32'h1C000700);
        bus_if.es_allowin = 1'b0;
        #1;
        chk("bp_allowin", bus_if.ds_allowin, 1'b0);
        b_hold = bus_if.ds2es_bus;
        @(posedge clk); #1;
        b = bus_if.ds2es_bus;
        chk("bp_valid",  bus_if.ds2es_valid, 1'b1);
        chk("bp_stable", b, b_hold);
        chk("bp_src1",   b.src1, 32'h12345678);
        bus_if.es_allowin = 1'b1;
        bus_if.fs2ds_valid = 1'b0;
        ms_fwd_zip = '0;
        idle();
        chk("bp_drain", bus_if.ds2es_valid, 1'b0);

        // ---- JIRL forwarding priority EX > MEM > WB ----
        issue({6'h13, 16'h0000, 5'd1, 5'd0}, 32'h1C000800);
        es_fwd_zip = {1'b1, 1'b1, 1'b0, 5'd1, 32'h1C000200};
        ms_fwd_zip = {1'b1, 1'b1, 1'b0, 5'd1, 32'h11111111};
        ws_rf_zip  = {1'b1, 5'd1, 32'h0};
        #1;
        chk("jirl_ex_wins",  bus_if.br_zip, {1'b1, 32'h1C000200});
        es_fwd_zip = '0;
        #1;
        chk("jirl_mem_wins", bus_if.br_zip, {1'b1, 32'h11111111});
        ms_fwd_zip = '0;
        #1;
        chk("jirl_wb",       bus_if.br_zip, {1'b1, 32'h00000000});
        ws_rf_zip = '0;
        idle();

        // ---- taken branch squashes the same-cycle fetch ----
        issue({6'h16, 16'h0010, 5'd1, 5'd2}, 32'h1C000100);
        bus_if.fs2ds_valid = 1'b1;
        bus_if.fs_inst = {10'h00a, 12'h001, 5'd0, 5'd4};
        bus_if.fs_pc = 32'h1C000104;
        #1;
        chk("beq_br",      bus_if.br_zip, {1'b1, 32'h1C000140});
        chk("beq_allowin", bus_if.ds_allowin, 1'b1);
        @(posedge clk); #1;
        bus_if.fs2ds_valid = 1'b0;
        chk("beq_squash",  bus_if.ds2es_valid, 1'b0);

        // ---- wb_ex flush while back-pressured ----
        issue({10'h00a, 12'h7ff, 5'd0, 5'd4}, 32'h1C000000);
        bus_if.es_allowin = 1'b0;
        #1;
        chk("fl_pre_valid",   bus_if.ds2es_valid, 1'b1);
        chk("fl_pre_allowin", bus_if.ds_allowin, 1'b0);
        wb_ex = 1'b1;
        #1;
        chk("fl_valid", bus_if.ds2es_valid, 1'b0);
        chk("fl_br",    bus_if.br_zip, 33'h0);
        @(posedge clk); #1;
        wb_ex = 1'b0;
        bus_if.es_allowin = 1'b1;
        #1;
        chk("fl_after_valid",   bus_if.ds2es_valid, 1'b0);
        chk("fl_after_allowin", bus_if.ds_allowin, 1'b1);

        // ---- ertn flush on a taken branch ----
        issue({6'h16, 16'h0010, 5'd1, 5'd2}, 32'h1C000100);
        ertn_flush = 1'b1;
        #1;
        chk("ertn_br",    bus_if.br_zip, 33'h0);
        chk("ertn_valid", bus_if.ds2es_valid, 1'b0);
        @(posedge clk); #1;
        ertn_flush = 1'b0;
        #1;
        chk("ertn_after_valid", bus_if.ds2es_valid, 1'b0);

        // ---- reset during a load-use stall; regfile contents persist ----
        issue({17'h20, 5'd5, 5'd5, 5'd6}, 32'h1C000900);
        es_fwd_zip = {1'b1, 1'b1, 1'b1, 5'd5, 32'h0};
        #1;
        chk("rst_stall_allowin", bus_if.ds_allowin, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        es_fwd_zip = '0;
        #1;
        chk("rst_stall_valid",   bus_if.ds2es_valid, 1'b0);
        chk("rst_stall_allowin2", bus_if.ds_allowin, 1'b1);
        chk("rst_stall_br",      bus_if.br_zip, 33'h0);
        issue({17'h20, 5'd7, 5'd1, 5'd8}, 32'h1C000A00);
        b = bus_if.ds2es_bus;
        chk("rf_persist_src1", b.src1, 32'h3);
        chk("rf_persist_src2", b.src2, 32'h5);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
